// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for pipeline stage boundaries: stage occupancy states and stage payloads.
package pipes;

    localparam int STAGE_OCC_W = 2;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_ONE   = 2'd1,
        STG_FULL  = 2'd2
    } stage_state_t;

    // Example stage payload; an IF/ID instance uses WIDTH = $bits(fetch_data_t).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    function automatic logic [STAGE_OCC_W-1:0] stage_occ(input stage_state_t s);
        case (s)
            STG_ONE:  return 2'd1;
            STG_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bundle around one pipeline stage register.
interface pipe_stage_reg_if
    import pipes::*;
#(
    parameter int WIDTH = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [STAGE_OCC_W-1:0] occupancy;

    // master: the surrounding pipeline (producer + consumer); slave: the stage itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry of a stage: WIDTH-bit data register plus valid bit.
module pipe_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Clear wins over load for the valid bit; data is only written on load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                data_q <= data_i;
            end
            if (clear_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush; define PIPE_SKID_EN to add a
// skid entry so in_ready comes from a register instead of from out_ready.
module pipe_stage_reg
    import pipes::*;
#(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus
);
    logic             accept;
    logic             rel;
    logic             main_load;
    logic             main_clr;
    logic             main_valid;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] main_dout;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_din),
        .data_o  (main_dout),
        .valid_o (main_valid)
    );

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_dout;
    assign accept        = bus.in_valid && bus.in_ready;
    assign rel           = main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    stage_state_t           state_q;
    stage_state_t           state_d;
    logic [STAGE_OCC_W-1:0] occ_q;
    logic                   skid_load;
    logic                   skid_clr;
    logic                   skid_valid;
    logic [WIDTH-1:0]       skid_dout;

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (bus.in_data),
        .data_o  (skid_dout),
        .valid_o (skid_valid)
    );

    assign bus.in_ready  = (state_q != STG_FULL);
    assign bus.occupancy = occ_q;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_din  = bus.in_data;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = STG_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                STG_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = STG_ONE;
                    end
                end
                STG_ONE: begin
                    if (accept && rel) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = STG_FULL;
                    end else if (rel) begin
                        main_clr = 1'b1;
                        state_d  = STG_EMPTY;
                    end
                end
                STG_FULL: begin
                    // Older skid beat moves forward so order is preserved.
                    if (rel) begin
                        main_load = 1'b1;
                        main_din  = skid_dout;
                        skid_clr  = 1'b1;
                        state_d   = STG_ONE;
                    end
                end
                default: state_d = STG_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STG_EMPTY;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= stage_occ(state_d);
        end
    end
`else
    assign bus.in_ready  = !main_valid || bus.out_ready;
    assign main_din      = bus.in_data;
    assign main_load     = accept && !flush;
    assign main_clr      = flush || (rel && !accept);
    assign bus.occupancy = {1'b0, main_valid};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner cases and a
// randomized run against a queue-based model of the stage (both PIPE_SKID_EN builds).
module tb_pipe_stage_reg;
    import pipes::*;

    localparam int W = 32;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(W)) bus ();

    pipe_stage_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];     // model: beats held by the stage, oldest first
    logic [W-1:0] seen[$];   // beats the DUT actually handed downstream
    logic [W-1:0] src[$];    // producer backlog for directed sequences
    logic         cur_v, cur_r, cur_f;
    logic [W-1:0] cur_d;
    logic         exp_rdy, last_acc;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        logic [W-1:0] ed;
        logic [1:0]   eo;
        logic         erdy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then check outputs against the model at the falling edge.
    task automatic drive_sample(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        cur_v = v; cur_d = d; cur_r = r; cur_f = f;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
        @(negedge clk);
`ifdef PIPE_SKID_EN
        exp_rdy = (mq.size() < CAP);
`else
        exp_rdy = (mq.size() == 0) || r;
`endif
        chk("in_ready", W'(bus.in_ready), W'(exp_rdy));
        chk("out_valid", W'(bus.out_valid), W'(mq.size() > 0));
        chk("occupancy", W'(bus.occupancy), W'(mq.size()));
        if (mq.size() > 0) chk("out_data", bus.out_data, mq[0]);
        if (prev_stall) chk("stall_stable", bus.out_data, prev_data);
`ifdef PIPE_SKID_EN
        bus.out_ready = !r;
        #1;
        chk("in_ready_no_comb", W'(bus.in_ready), W'(exp_rdy));
        bus.out_ready = r;
        #1;
`endif
        if (bus.out_valid && r) seen.push_back(bus.out_data);
        prev_stall = bus.out_valid && !r && !f;
        prev_data  = bus.out_data;
    endtask

    // Advance through the rising edge and update the model by the stage's rules.
    task automatic finish_cycle();
        logic rel;
        last_acc = cur_v && exp_rdy;
        rel      = (mq.size() > 0) && cur_r;
        @(posedge clk);
        if (rel) $display("deliver %h", mq.pop_front());
        if (cur_f) mq.delete();
        else if (last_acc) mq.push_back(cur_d);
        #1;
    endtask

    // Producer presents the head of src (held until accepted).
    task automatic offer(input logic r, input logic f);
        drive_sample(src.size() > 0, (src.size() > 0) ? src[0] : '0, r, f);
        finish_cycle();
        if (last_acc) void'(src.pop_front());
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) offer(1'b1, 1'b0);
    endtask

    initial begin
        int n_acc;
        logic         have;
        logic [W-1:0] seq;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #1;
        chk("reset_out_valid", W'(bus.out_valid), '0);
        chk("reset_occupancy", W'(bus.occupancy), '0);
        chk("reset_in_ready", W'(bus.in_ready), W'(1'b1));
        chk("reset_out_data", bus.out_data, '0);
        #11 reset = 1'b1;
        @(posedge clk); #1;

        // Streaming table: 8 beats back-to-back, then drain.
        for (int i = 0; i < 10; i++) begin
            tbl[i].v    = (i < 8);
            tbl[i].d    = (i < 8) ? W'(i + 1) : '0;
            tbl[i].r    = 1'b1;
            tbl[i].ev   = (i > 0 && i < 9);
            tbl[i].ed   = (i > 0 && i < 9) ? W'(i) : '0;
            tbl[i].eo   = (i > 0 && i < 9) ? 2'd1 : 2'd0;
            tbl[i].erdy = 1'b1;
        end
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            drive_sample(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("tbl%0d_valid", i), W'(bus.out_valid), W'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_occ", i), W'(bus.occupancy), W'(tbl[i].eo));
            chk($sformatf("tbl%0d_rdy", i), W'(bus.in_ready), W'(tbl[i].erdy));
            finish_cycle();
            $display("vector %0d in_v=%0d in_d=%h", i, tbl[i].v, tbl[i].d);
        end
        chk("stream_count", W'(seen.size()), W'(8));
        for (int i = 0; i < seen.size(); i++) chk("stream_order", seen[i], W'(i + 1));

        // Stall with A,B,C pending.
        seen.delete();
        src = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) offer(1'b0, 1'b0);
        drive_sample(1'b1, src[0], 1'b0, 1'b0);
        chk("stall_data", bus.out_data, 32'hA);
        chk("stall_occ", W'(bus.occupancy), W'(CAP));
        chk("stall_rdy", W'(bus.in_ready), '0);
        chk("stall_pending", W'(src.size()), W'(3 - CAP));
        finish_cycle();
        $display("stall with A,B,C offered");
        drain(8);
        chk("abc_count", W'(seen.size()), W'(3));
        for (int i = 0; i < seen.size(); i++) chk("abc_order", seen[i], W'(32'hA + i));

        // Flush while full, with 0x55 offered in the same cycle.
        seen.delete();
        src = '{32'h11, 32'h22};
        offer(1'b0, 1'b0);
        offer(1'b0, 1'b0);
        src.delete();
        drive_sample(1'b1, 32'h55, 1'b0, 1'b1);
        finish_cycle();
        drive_sample(1'b0, '0, 1'b0, 1'b0);
        chk("flush_valid", W'(bus.out_valid), '0);
        chk("flush_occ", W'(bus.occupancy), '0);
        finish_cycle();
        drain(3);
        chk("flush_nothing_out", W'(seen.size()), '0);
        $display("flush while full");

        // Flush that coincides with a release and an accept.
        seen.delete();
        src = '{32'h33};
        offer(1'b0, 1'b0);
        drive_sample(1'b1, 32'h66, 1'b1, 1'b1);
        finish_cycle();
        drain(3);
        chk("flush_rel_count", W'(seen.size()), W'(1));
        if (seen.size() > 0) chk("flush_rel_data", seen[0], 32'h33);
        $display("flush with release");

        // Asynchronous reset while holding a beat.
        src = '{32'hDEAD_BEEF};
        offer(1'b0, 1'b0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_out_valid", W'(bus.out_valid), '0);
        chk("areset_out_data", bus.out_data, '0);
        chk("areset_occ", W'(bus.occupancy), '0);
        chk("areset_in_ready", W'(bus.in_ready), W'(1'b1));
        mq.delete(); src.delete(); prev_stall = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        $display("async reset mid-operation");

        // Randomized traffic against the model.
        seen.delete();
        n_acc = 0; have = 1'b0; seq = 32'h1000;
        for (int i = 0; i < 1000; i++) begin
            if (!have) have = ($urandom_range(0, 3) != 0);
            drive_sample(have, have ? seq : '0, ($urandom_range(0, 2) != 0), 1'b0);
            finish_cycle();
            if (last_acc) begin
                have = 1'b0; seq++; n_acc++;
            end
        end
        have = 1'b0;
        drain(4);
        chk("rand_count", W'(seen.size()), W'(n_acc));
        for (int i = 0; i < seen.size(); i++) chk("rand_order", seen[i], W'(32'h1000 + i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline-stage register that generalises the fixed fetch/decode register into a reusable stage boundary for any `WIDTH`-bit payload. It supports valid/ready backpressure, stall by holding, and synchronous flush. It optionally adds a skid entry so that `in_ready` is driven from a register with no loss of throughput. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits; legal range ≥1.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset (0 = in reset).
- `flush`  in  1: synchronous flush; discards every held beat.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: stage can accept a beat.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: stage holds a beat for downstream.
- `out_ready`  in  1: downstream accepts; 0 = stall.
- `out_data`  out  WIDTH: payload of the oldest held beat.
- `occupancy`  out  2: number of held beats, 0..2 (always ≤1 without skid).

## Operation
- Handshakes:
  - Accept = `in_valid && in_ready`.
  - Release = `out_valid && out_ready`.
- Beats leave in arrival order. No beat is duplicated or lost, except on flush.
- `out_data` is only meaningful while `out_valid=1`. Held data stays stable while `out_valid && !out_ready`.
- Base mode (single main entry):
  - `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
  - Accept and release in the same cycle replace the entry, giving 1 beat/cycle.
- Skid mode (main + skid entries): states are EMPTY, ONE and FULL.
  - EMPTY: accept → ONE.
  - ONE, accept only → FULL. The new beat goes to skid.
  - ONE, release only → EMPTY.
  - ONE, accept + release → stays ONE. Main takes `in_data`.
  - FULL: `in_ready=0`. Release → ONE, and skid moves to main.
  - `in_ready = (state != FULL)`, taken from the registered state.
- Flush:
  - Highest priority. The next state is EMPTY and all valid bits clear.
  - A beat accepted in the flush cycle is discarded.
  - A release in the flush cycle still counts as delivered downstream.
  - Data registers keep their stale contents.
- Reset (async assert, synchronous-safe deassert by the system):
  - `out_valid=0`, `occupancy=0`, `out_data='0`.
  - `in_ready=1`.
  - State is EMPTY and the skid contents are `'0`.
- `occupancy` is registered and equals the number of valid entries.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle while `out_ready=1`.
- Stall: when `out_ready` drops, `out_valid`/`out_data` hold with no bubble or repeat.
  - Base mode: `in_ready` falls in the same cycle.
  - Skid mode: one more beat is absorbed, and `in_ready` falls the cycle after.
- Resume from FULL: `in_ready` returns 1 the cycle after the first release.
- `flush` takes effect at the next edge: `out_valid=0` from that edge on.
- Reset mid-operation: outputs take reset values immediately (asynchronously), and all held beats are dropped.

## Configuration
- `PIPE_SKID_EN` defined:
  - The skid entry and the 3-state machine are built.
  - `in_ready` is registered, with no combinational `out_ready`→`in_ready` path.
  - `occupancy` ranges 0..2.
- `PIPE_SKID_EN` undefined:
  - Base mode only, with `in_ready` combinational.
  - `occupancy[1]` is tied to 0.
  - No skid storage is instantiated.

## Structure
- `pipes` package:
  - `stage_state_t` enum {`STG_EMPTY`, `STG_ONE`, `STG_FULL`}.
  - `STAGE_OCC_W = 2`.
- Stage-specific payload structs (e.g. `fetch_data_t`) stay in `pipes`. Instances set `WIDTH = $bits(<struct>)` and cast at the ports.
- One sub-module, `pipe_slot`: a `WIDTH`-bit data register plus valid bit, with async active-low reset and load/clear enables. It is instantiated once for main and, under `PIPE_SKID_EN`, once for skid.

## Test plan
- Reset while holding `0xDEAD_BEEF` → `out_valid=0`, `out_data=0`, `occupancy=0`, `in_ready=1` immediately, without waiting for a clock.
- Stream 8 beats `0x1..0x8` with `out_ready=1` → outputs `0x1..0x8` in order, one per cycle, 1-cycle latency, no bubbles.
- Send `0xA`, `0xB`, `0xC` with `out_ready=0`:
  - Skid build: `0xA` and `0xB` held, `occupancy=2`, `in_ready=0`, `0xC` waits.
  - Base build: only `0xA` is held.
  - Raising `out_ready` drains `0xA`, `0xB`, `0xC` in order.
- Assert `flush` while FULL, together with an accept of `0x55` → `out_valid=0` and `occupancy=0` next cycle, and `0x55` never appears.
- Toggle `out_ready` randomly for 1000 cycles with random `in_valid` → a scoreboard sees no loss, duplication or reorder. `out_data` stays stable while stalled.
- Skid build: check that `in_ready` is constant within each cycle regardless of `out_ready` (no combinational dependency).
